fp32_acc_seq: RTL and testbench
===============================

// Module: fp32_acc_seq
// PURPOSE
//  Sequencer that sits directly upstream of the registered FP32 add/select stage and closes its feedback loop.
//  - Accepts a job of `len` FP32 operands on a valid/ready stream.
//  - Drives the stage's A/B/ctrl inputs so the stage register accumulates the running sum.
//  - Presents the final sum on a valid/ready result port.
//  - Throughput: one operand per cycle; the stage's 1-cycle registered latency is hidden by the feedback wiring.
// PARAMETERS
//  LEN_W  8  width of job length / element counter; max job = 2**LEN_W-1 operands
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  start      in   1      job request; sampled only in IDLE
//  len        in   LEN_W  operand count for the job, sampled with start
//  in_valid   in   1      operand valid
//  in_data    in   32     FP32 operand
//  in_ready   out  1      operand accepted when in_valid & in_ready
//  add_a      out  32     to stage A input; always equal to add_out (feedback)
//  add_b      out  32     to stage B input; always equal to in_data
//  add_ctrl   out  3      to stage ctrl, one-hot: [2] pass A, [1] pass B, [0] A+B, 000 gives +0.0
//  add_out    in   32     registered output of the stage (same clk/rst_n; resets to 0)
//  res_valid  out  1      final sum valid
//  res_data   out  32     final sum (= add_out while res_valid)
//  res_ready  in   1      result consumed when res_valid & res_ready
//  busy       out  1      state != IDLE
// BEHAVIOUR
//  - Reset (async, any cycle, including mid-job):
//    - state=IDLE, cnt=0, in_ready=0, res_valid=0, busy=0, add_ctrl=100.
//    - The stage output clears to 0 on the same reset. Any partial job is discarded.
//  - FSM states: IDLE, FIRST, ACC, DONE. Registers: state, cnt[LEN_W-1:0]. add_ctrl, in_ready, res_valid are decoded combinationally from state and inputs.
//  - IDLE:
//    - in_ready=0. add_ctrl=100 (hold) by default.
//    - start & len!=0: cnt<=len, go FIRST.
//    - start & len==0: add_ctrl=000 this cycle, so the stage loads +0.0; go DONE.
//  - FIRST:
//    - in_ready=1.
//    - On accept: add_ctrl=010 (load operand), cnt<=cnt-1; go DONE if cnt==1, else ACC.
//    - No accept: add_ctrl=100 (hold).
//  - ACC:
//    - in_ready=1.
//    - On accept: add_ctrl=001 (sum<=sum+operand), cnt<=cnt-1; go DONE if cnt==1, else stay.
//    - Bubble (in_valid=0): add_ctrl=100; sum and cnt unchanged.
//  - DONE:
//    - res_valid=1, res_data=add_out, add_ctrl=100 (value held stable), in_ready=0.
//    - res_ready: go IDLE.
//  - Latency:
//    - Last operand accepted at cycle t gives res_valid at t+1.
//    - len==0 start at cycle t gives res_valid at t+1 with 0x00000000.
//  - start outside IDLE is ignored (including in DONE with res_ready=1). A new job needs start while in IDLE.
//  - in_valid outside FIRST/ACC is ignored; no operand is consumed.
//  - Operand order is the accept order; summation is strictly left-to-right.
//  - Rounding and special values (NaN/Inf/denormal) follow the stage adder; no checks here.
//  - cnt never wraps: decrement happens only on accept while cnt>=1.
// TESTING
//  1. len=4; operands 1.0,2.0,3.0,4.0 (0x3F800000,0x40000000,0x40400000,0x40800000) back-to-back
//     -> res_data=0x41200000 (10.0), res_valid 1 cycle after 4th accept.
//  2. len=1; operand 0x40490FDB -> res_data=0x40490FDB; add_ctrl=010 on the accept cycle.
//  3. start with len=0 -> add_ctrl=000 that cycle; next cycle res_valid=1, res_data=0x00000000.
//  4. len=3 of 1.0 with in_valid low 2 cycles between operands
//     -> add_ctrl=100 in bubbles; res_data=0x40400000; res_ready low 5 cycles keeps data stable.
//  5. Assert rst_n=0 after 2 of 4 operands -> next edge-free check shows state IDLE, busy=0, in_ready=0;
//     a new len=2 job of 2.0,2.0 then yields 0x40800000.
//  6. start pulsed while busy (ACC and DONE) -> ignored; the running job result is unchanged and the FSM returns to IDLE.

Source files
------------

// File: rtl/fp32_acc_seq.sv
// ---------------------------------------------------------------------------
// fp32_acc_seq
//   Sequencer that drives a registered FP32 add/select stage so that the
//   stage register accumulates a running sum of a job of `len` operands.
//   The stage output is fed straight back to its A input, and the incoming
//   operand goes straight to its B input. Only the one-hot control word is
//   decided here, so one operand can be absorbed per cycle even though the
//   stage has one cycle of registered latency.
//
// Ports
//   clk, rst_n          clock / asynchronous active-low reset
//   start, len          job request and operand count, sampled in IDLE only
//   in_valid, in_data   operand stream (accepted on in_valid & in_ready)
//   in_ready            high while the job is collecting operands
//   add_a, add_b        stage A/B inputs (feedback and operand)
//   add_ctrl            stage control, one-hot:
//                         100 pass A (hold), 010 pass B (load),
//                         001 A+B (accumulate), 000 load +0.0
//   add_out             registered stage output
//   res_valid, res_data final-sum handshake (res_data mirrors add_out)
//   res_ready           result consumer ready
//   busy                high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module fp32_acc_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    output logic [2:0]       add_ctrl,
    input  logic [31:0]      add_out,
    output logic             res_valid,
    output logic [31:0]      res_data,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_ACC   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] CTRL_HOLD = 3'b100;
    localparam logic [2:0] CTRL_LOAD = 3'b010;
    localparam logic [2:0] CTRL_ADD  = 3'b001;
    localparam logic [2:0] CTRL_ZERO = 3'b000;

    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q,   cnt_d;
    logic             accept;

    // Feedback wiring: the stage always sees its own output on A and the
    // live operand on B; the control word alone selects what it stores.
    assign add_a    = add_out;
    assign add_b    = in_data;
    assign res_data = add_out;
    assign busy     = (state_q != S_IDLE);
    assign accept   = in_valid & in_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. cnt is only decremented on an accept in FIRST/ACC,
    // where it is at least 1 by construction, so it can never wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = S_FIRST;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FIRST, S_ACC: begin
                if (accept) begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = (cnt_q == CNT_ONE) ? S_DONE : S_ACC;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
        add_ctrl  = CTRL_HOLD;
        case (state_q)
            S_IDLE: begin
                // An empty job still has to present a clean +0.0 result.
                if (start && (len == '0)) begin
                    add_ctrl = CTRL_ZERO;
                end
            end
            S_FIRST: begin
                in_ready = 1'b1;
                // First operand overwrites whatever the stage held before.
                if (in_valid) begin
                    add_ctrl = CTRL_LOAD;
                end
            end
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    add_ctrl = CTRL_ADD;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
            end
            default: begin
                add_ctrl = CTRL_HOLD;
            end
        endcase
    end

endmodule

// File: tb/tb_fp32_acc_seq.sv
module tb_fp32_acc_seq;

    localparam int LEN_W = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [2:0]       add_ctrl;
    logic [31:0]      add_out;
    logic             res_valid;
    logic [31:0]      res_data;
    logic             res_ready;
    logic             busy;

    int n_total = 0;
    int n_pass  = 0;

    fp32_acc_seq #(.LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_ctrl (add_ctrl),
        .add_out  (add_out),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_ready(res_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- FP32 helpers (normal numbers and zero only) --------
    function automatic real fp32_to_real(input logic [31:0] b);
        real v;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        v = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] real_to_fp32(input real x);
        real         m;
        int          e;
        logic        s;
        longint      fr;
        logic [31:0] r;
        if (x == 0.0) return 32'h0000_0000;
        s = (x < 0.0);
        m = s ? -x : x;
        e = 127;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        fr = longint'((m - 1.0) * 8388608.0);
        r  = {s, e[7:0], fr[22:0]};
        return r;
    endfunction

    // ---------------- Stage model: registered add/select ------------------
    logic [31:0] stage_q;
    assign add_out = stage_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= 32'h0;
        end else begin
            case (add_ctrl)
                3'b100:  stage_q <= add_a;
                3'b010:  stage_q <= add_b;
                3'b001:  stage_q <= real_to_fp32(fp32_to_real(add_a) + fp32_to_real(add_b));
                3'b000:  stage_q <= 32'h0;
                default: stage_q <= 32'hDEAD_BEEF;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // ---------------- Behavioural job model + per-cycle compare ----------
    // The job is described by: is it collecting, how many operands remain,
    // has the first arrived, is a result pending, and the running sum.
    bit       m_active, m_first, m_result;
    int       m_remain;
    real      m_sum;
    logic [2:0] e_ctrl;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_active = 0; m_first = 0; m_result = 0; m_remain = 0; m_sum = 0.0;
            check("rst_busy",      {31'd0, busy},      32'd0);
            check("rst_in_ready",  {31'd0, in_ready},  32'd0);
            check("rst_res_valid", {31'd0, res_valid}, 32'd0);
            check("rst_add_out",   add_out,            32'h0);
        end else begin
            e_ctrl = 3'b100;
            if (!m_active && !m_result && start && len == 0) e_ctrl = 3'b000;
            if (m_active && in_valid) e_ctrl = m_first ? 3'b010 : 3'b001;
            check("in_ready",  {31'd0, in_ready},  {31'd0, m_active});
            check("res_valid", {31'd0, res_valid}, {31'd0, m_result});
            check("busy",      {31'd0, busy},      {31'd0, (m_active | m_result)});
            check("add_ctrl",  {29'd0, add_ctrl},  {29'd0, e_ctrl});
            check("add_a",     add_a, add_out);
            check("add_b",     add_b, in_data);
            if (m_result) check("res_data", res_data, real_to_fp32(m_sum));
            // advance the model with the inputs the next edge will sample
            if (m_result) begin
                if (res_ready) m_result = 0;
            end else if (m_active) begin
                if (in_valid) begin
                    m_sum = m_first ? fp32_to_real(in_data) : m_sum + fp32_to_real(in_data);
                    m_first = 0;
                    m_remain--;
                    if (m_remain == 0) begin m_active = 0; m_result = 1; end
                end
            end else if (start) begin
                if (len == 0) begin m_result = 1; m_sum = 0.0; end
                else begin m_active = 1; m_first = 1; m_remain = int'(len); end
            end
        end
    end

    // ---------------- Stimulus ------------------------------------------
    logic [31:0] op_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // bub < 0 selects random bubbles; poke pulses start while busy.
    task automatic do_job(input int n, input int bub, input int rr_wait,
                          input logic [31:0] exp, input bit poke, input string tag);
        int b;
        start = 1'b1;
        len   = n[LEN_W-1:0];
        if (n == 0) begin
            #1;
            check({tag, "_len0_ctrl"}, {29'd0, add_ctrl}, {29'd0, 3'b000});
        end
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = op_q[i];
            if (poke && i == 1) begin start = 1'b1; len = 8'd3; end
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
            in_data  = $urandom;
            if (i < n - 1) begin
                b = (bub < 0) ? $urandom_range(0, 2) : bub;
                repeat (b) begin
                    tick();
                    in_data = $urandom;
                end
            end
        end
        check({tag, "_res_valid_lat"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_res_data"}, res_data, exp);
        for (int k = 0; k < rr_wait; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            tick();
            check({tag, "_res_hold"}, res_data, exp);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        if (poke) begin start = 1'b1; len = 8'd2; end
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        check({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
        tick();
        check({tag, "_still_idle"}, {31'd0, busy}, 32'd0);
        $display("job %s len=%0d result=%h expected=%h", tag, n, res_data, exp);
    endtask

    initial begin
        real         s;
        int          n;
        int          k;
        logic [31:0] r;

        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_data = 32'h0; res_ready = 1'b0;

        // pin the model's number conversions
        r = real_to_fp32(10.0);
        check("model_10", r, 32'h41200000);
        r = real_to_fp32(fp32_to_real(32'h40490FDB));
        check("model_pi", r, 32'h40490FDB);

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // 1: 1+2+3+4 back to back
        op_q = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        do_job(4, 0, 0, 32'h41200000, 1'b0, "t1");

        // 2: single operand passes through
        op_q = '{32'h40490FDB};
        start = 1'b1; len = 8'd1;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 32'h40490FDB;
        #1;
        check("t2_load_ctrl", {29'd0, add_ctrl}, {29'd0, 3'b010});
        tick();
        in_valid = 1'b0;
        check("t2_res_data", res_data, 32'h40490FDB);
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        $display("job t2 len=1 result=%h expected=40490fdb", add_out);

        // 3: empty job
        op_q.delete();
        do_job(0, 0, 1, 32'h00000000, 1'b0, "t3");

        // 4: bubbles between operands, result held while not consumed
        op_q = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
        do_job(3, 2, 5, 32'h40400000, 1'b0, "t4");

        // 5: reset in the middle of a job
        start = 1'b1; len = 8'd4; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 32'h3F800000; tick();
        end
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk); #1;
        check("t5_busy",      {31'd0, busy},      32'd0);
        check("t5_in_ready",  {31'd0, in_ready},  32'd0);
        check("t5_res_valid", {31'd0, res_valid}, 32'd0);
        check("t5_add_ctrl",  {29'd0, add_ctrl},  {29'd0, 3'b100});
        @(posedge clk); #2 rst_n = 1'b1;
        $display("reset t5 busy=%0b in_ready=%0b", busy, in_ready);
        op_q = '{32'h40000000, 32'h40000000};
        do_job(2, 0, 0, 32'h40800000, 1'b0, "t5");

        // 6: start pulsed in ACC and in DONE is ignored
        op_q = '{32'h40000000, 32'h40400000, 32'h40800000};
        do_job(3, 1, 1, 32'h41100000, 1'b1, "t6");

        // randomized jobs of small integers (sums stay exact)
        for (int j = 0; j < 40; j++) begin
            op_q.delete();
            n = (j % 7 == 0) ? 0 : $urandom_range(1, 12);
            s = 0.0;
            for (int i = 0; i < n; i++) begin
                k = int'($urandom_range(0, 40)) - 20;
                op_q.push_back(real_to_fp32(real'(k)));
                s = s + real'(k);
            end
            do_job(n, -1, $urandom_range(0, 3), real_to_fp32(s),
                   1'($urandom_range(0, 1)), $sformatf("r%0d", j));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        n_total++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
